// File: rtl/seq_signed_divider_if.sv
// Request/response bundle for the iterative signed divider.
interface seq_signed_divider_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 busy;
  logic                 done;
  logic                 div_by_zero;
  logic                 overflow;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_signed_divider.sv
// Iterative 2W/W signed divider: restoring division on magnitudes, one quotient
// bit per clock, signs and saturation applied in a final fix-up cycle.
module seq_signed_divider #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_signed_divider_if.slave  io
);
  localparam int CW = $clog2(2*WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, ZERO} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]        cnt;
  logic [WIDTH:0]       pr;
  logic [2*WIDTH-1:0]   dq;
  logic [WIDTH-1:0]     dvs;
  logic                 neg_q, neg_r;

  logic [WIDTH-1:0]     quotient_q, remainder_q;
  logic                 busy_q, done_q, dbz_q, ovf_q;

  logic                 last;
  logic [WIDTH:0]       shifted;
  logic [WIDTH+1:0]     trial;
  logic                 take;
  logic [2*WIDTH-1:0]   dividend_abs;
  logic [WIDTH-1:0]     divisor_abs;
  logic [2*WIDTH-1:0]   lim_neg, lim_pos;
  logic                 q_ovf;
  logic [WIDTH-1:0]     q_signed, r_signed, lo_signed;

  assign last = (cnt == CW'(2*WIDTH-1));

  // Most-negative inputs negate to themselves, which reads correctly as unsigned.
  assign dividend_abs = io.dividend[2*WIDTH-1] ? -io.dividend : io.dividend;
  assign divisor_abs  = io.divisor[WIDTH-1]    ? -io.divisor  : io.divisor;

  // Partial remainder stays below |divisor| <= 2^(WIDTH-1), so its top bit is free.
  assign shifted = {pr[WIDTH-1:0], dq[2*WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, dvs};
  assign take    = ~trial[WIDTH+1];

  assign lim_neg  = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
  assign lim_pos  = lim_neg - 1'b1;
  assign q_ovf    = neg_q ? (dq > lim_neg) : (dq > lim_pos);
  assign q_signed = neg_q ? -dq[WIDTH-1:0] : dq[WIDTH-1:0];
  assign r_signed = neg_r ? -pr[WIDTH-1:0] : pr[WIDTH-1:0];
  // In ZERO the magnitude register is untouched; re-signing it recovers the raw low bits.
  assign lo_signed = neg_r ? -dq[WIDTH-1:0] : dq[WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (io.start) state_nxt = (io.divisor == '0) ? ZERO : CALC;
      CALC: if (last)     state_nxt = FIX;
      FIX:                state_nxt = IDLE;
      ZERO:               state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pr          <= '0;
      dq          <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;
      case (state)
        IDLE: if (io.start) begin
          dq     <= dividend_abs;
          dvs    <= divisor_abs;
          pr     <= '0;
          neg_q  <= io.dividend[2*WIDTH-1] ^ io.divisor[WIDTH-1];
          neg_r  <= io.dividend[2*WIDTH-1];
          cnt    <= '0;
          busy_q <= 1'b1;
          dbz_q  <= 1'b0;
          ovf_q  <= 1'b0;
        end
        CALC: begin
          pr  <= take ? trial[WIDTH:0] : shifted;
          dq  <= {dq[2*WIDTH-2:0], take};
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          ovf_q  <= q_ovf;
          if (q_ovf) begin
            quotient_q  <= neg_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            remainder_q <= '0;
          end else begin
            quotient_q  <= q_signed;
            remainder_q <= r_signed;
          end
        end
        ZERO: begin
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          dbz_q       <= 1'b1;
          quotient_q  <= '1;
          remainder_q <= lo_signed;
        end
        default: ;
      endcase
    end
  end

  assign io.quotient    = quotient_q;
  assign io.remainder   = remainder_q;
  assign io.busy        = busy_q;
  assign io.done        = done_q;
  assign io.div_by_zero = dbz_q;
  assign io.overflow    = ovf_q;
endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed bench for seq_signed_divider: hand-computed quotients, flags and latencies.
module tb_seq_signed_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  seq_signed_divider_if #(.WIDTH(32)) io ();
  seq_signed_divider #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .io(io));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one start pulse, returns edges from start edge to done and busy-high cycles.
  task automatic run(input logic [63:0] a, input logic [31:0] b, output int lat, output int bsy);
    io.dividend = a;
    io.divisor  = b;
    io.start    = 1'b1;
    @(posedge clk); #1;
    io.start    = 1'b0;
    io.dividend = '0;
    io.divisor  = '0;
    lat = 0;
    bsy = io.busy ? 1 : 0;
    while (!io.done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (io.busy) bsy++;
    end
    if (lat >= 200) chk("timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int lat, bsy, seen;
    io.start = 1'b0; io.dividend = '0; io.divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_q",   io.quotient,  32'd0);
    chk("rst_r",   io.remainder, 32'd0);
    chk("rst_bsy", {31'd0, io.busy}, 32'd0);
    chk("rst_dn",  {31'd0, io.done}, 32'd0);
    chk("rst_flg", {30'd0, io.div_by_zero, io.overflow}, 32'd0);

    run(-64'sd2000, -32'sd40, lat, bsy);
    chk("t1_lat", lat, 32'd65);
    chk("t1_bsy", bsy, 32'd65);
    chk("t1_q", io.quotient, 32'd50);
    chk("t1_r", io.remainder, 32'd0);
    chk("t1_flg", {30'd0, io.div_by_zero, io.overflow}, 32'd0);
    @(posedge clk); #1;
    chk("t1_pulse", {31'd0, io.done}, 32'd0);

    run(64'sd5201, -32'sd65, lat, bsy);
    chk("s1_q", io.quotient, -32'sd80);
    chk("s1_r", io.remainder, 32'd1);
    run(-64'sd3251, 32'sd325, lat, bsy);
    chk("s2_q", io.quotient, -32'sd10);
    chk("s2_r", io.remainder, -32'sd1);
    run(-64'sd998001, 32'sd999, lat, bsy);
    chk("s3_q", io.quotient, -32'sd999);
    chk("s3_r", io.remainder, 32'd0);

    run(64'sd98765, 32'd0, lat, bsy);
    chk("z_lat", lat, 32'd1);
    chk("z_dbz", {31'd0, io.div_by_zero}, 32'd1);
    chk("z_q", io.quotient, 32'hFFFF_FFFF);
    chk("z_r", io.remainder, 32'd98765);

    run(64'h0000_0001_0000_0000, 32'd1, lat, bsy);
    chk("o1_ovf", {31'd0, io.overflow}, 32'd1);
    chk("o1_q", io.quotient, 32'h7FFF_FFFF);
    chk("o1_r", io.remainder, 32'd0);
    chk("o1_dbz", {31'd0, io.div_by_zero}, 32'd0);
    run(64'hFFFF_FFFF_8000_0000, 32'hFFFF_FFFF, lat, bsy);
    chk("o2_ovf", {31'd0, io.overflow}, 32'd1);
    chk("o2_q", io.quotient, 32'h7FFF_FFFF);
    run(64'hFFFF_FFFF_8000_0000, 32'd1, lat, bsy);
    chk("o3_ovf", {31'd0, io.overflow}, 32'd0);
    chk("o3_q", io.quotient, 32'h8000_0000);
    chk("o3_r", io.remainder, 32'd0);

    // Ignored start mid-flight, then back-to-back start in the done cycle.
    io.dividend = 64'd6300; io.divisor = 32'd70; io.start = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    lat = 0;
    while (!io.done && lat < 200) begin
      if (lat == 9) begin io.start = 1'b1; io.dividend = 64'd1; io.divisor = 32'd1; end
      else begin io.start = 1'b0; io.dividend = 64'd7; io.divisor = 32'd3; end
      @(posedge clk); #1;
      lat++;
    end
    io.start = 1'b0;
    chk("h1_lat", lat, 32'd65);
    chk("h1_q", io.quotient, 32'd90);
    chk("h1_r", io.remainder, 32'd0);
    io.dividend = 64'd6300; io.divisor = -32'sd70; io.start = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    chk("h2_bsy", {31'd0, io.busy}, 32'd1);
    lat = 0;
    while (!io.done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("h2_lat", lat, 32'd65);
    chk("h2_q", io.quotient, -32'sd90);

    // Reset mid-operation.
    io.dividend = 64'd1000000; io.divisor = -32'sd500; io.start = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mr_q", io.quotient, 32'd0);
    chk("mr_r", io.remainder, 32'd0);
    chk("mr_bsy", {31'd0, io.busy}, 32'd0);
    chk("mr_flg", {30'd0, io.div_by_zero, io.overflow}, 32'd0);
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (io.done) seen++;
    end
    chk("mr_nodone", seen, 32'd0);
    run(64'd98765, 32'd1, lat, bsy);
    chk("mr_next_q", io.quotient, 32'd98765);
    chk("mr_next_lat", lat, 32'd65);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
